// File: rtl/player_motion.sv
// player_motion
//   Per-frame physics and control for the player sprite. On each frame_tick
//   while airborne it moves the player horizontally with screen wrap. It runs
//   the rise/fall state machine with gravity and restarts a jump when the
//   player lands on a platform. It clamps the sprite at a ceiling line and
//   reports the excess rise as scroll. It flags death when the sprite passes
//   the bottom of the screen.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   start             level, begins or restarts the game from IDLE/DEAD
//   move_left/right   horizontal controls, sampled at frame_tick
//   land              feet-on-platform flag, sampled at frame_tick
//   pos_x, pos_y      sprite top-left position (to the address generator)
//   vel_y             current vertical speed magnitude
//   falling, dead     state flags
//   facing_left       sprite horizontal flip select
//   scroll            world scroll produced by the last frame update
//   upd               one-cycle pulse, the cycle after a frame update
module player_motion #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PLAYER_H = 60,
  parameter int unsigned START_X  = 300,
  parameter int unsigned START_Y  = 400,
  parameter int unsigned CEIL_Y   = 160,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned MAX_FALL = 12,
  parameter int unsigned STEP_X   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       land,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [3:0] vel_y,
  output logic       falling,
  output logic       dead,
  output logic       facing_left,
  output logic [9:0] scroll,
  output logic       upd
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_DEAD    = 2'd3
  } state_t;

  localparam logic [10:0]        SCREEN_W_C = 11'(SCREEN_W);
  localparam logic [10:0]        SCREEN_H_C = 11'(SCREEN_H);
  localparam logic [10:0]        PLAYER_H_C = 11'(PLAYER_H);
  localparam logic [10:0]        STEP_X_C   = 11'(STEP_X);
  localparam logic signed [10:0] CEIL_C     = 11'(CEIL_Y);
  localparam logic [9:0]         START_X_C  = 10'(START_X);
  localparam logic [9:0]         START_Y_C  = 10'(START_Y);
  localparam logic [9:0]         CEIL_Y_C   = 10'(CEIL_Y);
  localparam logic [3:0]         JUMP_V_C   = 4'(JUMP_V);
  localparam logic [3:0]         MAX_FALL_C = 4'(MAX_FALL);

  state_t     state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [3:0] vel_y_q, vel_y_d;
  logic [9:0] scroll_q, scroll_d;
  logic       facing_left_q, facing_left_d;
  logic       falling_q, falling_d;
  logic       dead_q, dead_d;
  logic       upd_q, upd_d;

  // 11-bit working copies so that wrap, ceiling and floor tests cannot overflow.
  logic [10:0]        x_ext_s;
  logic [10:0]        y_ext_s;
  logic signed [10:0] rise_y_s;
  logic [3:0]         fall_vel_s;
  logic [10:0]        fall_y_s;

  // Candidate vertical positions for this frame, before the state selects one.
  always_comb begin
    x_ext_s  = {1'b0, pos_x_q};
    y_ext_s  = {1'b0, pos_y_q};
    rise_y_s = $signed(y_ext_s - {7'd0, vel_y_q});
    if (vel_y_q >= MAX_FALL_C) begin
      fall_vel_s = MAX_FALL_C;
    end else begin
      fall_vel_s = vel_y_q + 4'd1;
    end
    fall_y_s = y_ext_s + {7'd0, fall_vel_s};
  end

  // Next-state and next-output logic for the motion state machine.
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    vel_y_d       = vel_y_q;
    scroll_d      = scroll_q;
    facing_left_d = facing_left_q;
    upd_d         = 1'b0;

    case (state_q)
      ST_IDLE, ST_DEAD: begin
        // start wins over a coincident frame_tick: spawn, no motion this frame.
        if (start) begin
          state_d  = ST_RISING;
          pos_x_d  = START_X_C;
          pos_y_d  = START_Y_C;
          vel_y_d  = JUMP_V_C;
          scroll_d = 10'd0;
        end else begin
          state_d = state_q;
        end
      end

      ST_RISING, ST_FALLING: begin
        if (frame_tick) begin
          upd_d = 1'b1;

          // Horizontal step with wrap; both or neither held means no move.
          if (move_left && !move_right) begin
            facing_left_d = 1'b1;
            if (x_ext_s < STEP_X_C) begin
              pos_x_d = 10'(x_ext_s + SCREEN_W_C - STEP_X_C);
            end else begin
              pos_x_d = 10'(x_ext_s - STEP_X_C);
            end
          end else if (move_right && !move_left) begin
            facing_left_d = 1'b0;
            if ((x_ext_s + STEP_X_C) >= SCREEN_W_C) begin
              pos_x_d = 10'(x_ext_s + STEP_X_C - SCREEN_W_C);
            end else begin
              pos_x_d = 10'(x_ext_s + STEP_X_C);
            end
          end else begin
            pos_x_d = pos_x_q;
          end

          if (state_q == ST_RISING) begin
            // Rise above the ceiling line turns into world scroll.
            if (rise_y_s < CEIL_C) begin
              pos_y_d  = CEIL_Y_C;
              scroll_d = 10'(CEIL_C - rise_y_s);
            end else begin
              pos_y_d  = 10'(rise_y_s);
              scroll_d = 10'd0;
            end
            vel_y_d = vel_y_q - 4'd1;
            if (vel_y_q == 4'd1) begin
              state_d = ST_FALLING;
            end else begin
              state_d = ST_RISING;
            end
          end else begin
            scroll_d = 10'd0;
            if (land) begin
              vel_y_d = JUMP_V_C;
              state_d = ST_RISING;
            end else begin
              vel_y_d = fall_vel_s;
              // Sprite bottom past the screen edge: pin to the floor and die.
              if ((fall_y_s + PLAYER_H_C) > SCREEN_H_C) begin
                pos_y_d = 10'(SCREEN_H_C - PLAYER_H_C);
                state_d = ST_DEAD;
              end else begin
                pos_y_d = 10'(fall_y_s);
                state_d = ST_FALLING;
              end
            end
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    falling_d = (state_d == ST_FALLING);
    dead_d    = (state_d == ST_DEAD);
  end

  // State and output registers with asynchronous reset to the spawn position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pos_x_q       <= START_X_C;
      pos_y_q       <= START_Y_C;
      vel_y_q       <= 4'd0;
      scroll_q      <= 10'd0;
      facing_left_q <= 1'b0;
      falling_q     <= 1'b0;
      dead_q        <= 1'b0;
      upd_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vel_y_q       <= vel_y_d;
      scroll_q      <= scroll_d;
      facing_left_q <= facing_left_d;
      falling_q     <= falling_d;
      dead_q        <= dead_d;
      upd_q         <= upd_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign vel_y       = vel_y_q;
  assign falling     = falling_q;
  assign dead        = dead_q;
  assign facing_left = facing_left_q;
  assign scroll      = scroll_q;
  assign upd         = upd_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed scenarios followed by
// randomized frames, all compared against an arithmetic reference model.
module tb_player_motion;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       move_left;
  logic       move_right;
  logic       land;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] vel_y;
  logic       falling;
  logic       dead;
  logic       facing_left;
  logic [9:0] scroll;
  logic       upd;

  player_motion dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .move_left   (move_left),
    .move_right  (move_right),
    .land        (land),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_y       (vel_y),
    .falling     (falling),
    .dead        (dead),
    .facing_left (facing_left),
    .scroll      (scroll),
    .upd         (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: game state as plain integers.
  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_FALL = 2;
  localparam int M_DEAD = 3;

  int m_state, m_x, m_y, m_v, m_scroll, m_face, m_upd;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input int expv);
    n_assert++;
    assert (obs === 16'(expv)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_x = 300; m_y = 400; m_v = 0;
    m_scroll = 0; m_face = 0; m_upd = 0;
  endtask

  // One clock edge of game behaviour, written from the game rules directly.
  task automatic model_edge(input bit st, input bit tk, input bit ml, input bit mr, input bit ld);
    int t;
    m_upd = 0;
    if (m_state == M_IDLE || m_state == M_DEAD) begin
      if (st) begin
        m_state = M_RISE; m_x = 300; m_y = 400; m_v = 12; m_scroll = 0;
      end
    end else if (tk) begin
      m_upd = 1;
      if (ml && !mr) begin
        m_face = 1; m_x = (m_x + 640 - 4) % 640;
      end else if (mr && !ml) begin
        m_face = 0; m_x = (m_x + 4) % 640;
      end
      if (m_state == M_RISE) begin
        t = m_y - m_v;
        m_scroll = (t < 160) ? 160 - t : 0;
        m_y = (t < 160) ? 160 : t;
        m_v = m_v - 1;
        if (m_v == 0) m_state = M_FALL;
      end else begin
        m_scroll = 0;
        if (ld) begin
          m_v = 12; m_state = M_RISE;
        end else begin
          m_v = (m_v + 1 > 12) ? 12 : m_v + 1;
          m_y = m_y + m_v;
          if (m_y + 60 > 480) begin
            m_y = 420; m_state = M_DEAD;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".pos_x"},   {6'd0, pos_x},        m_x);
    chk({ph, ".pos_y"},   {6'd0, pos_y},        m_y);
    chk({ph, ".vel_y"},   {12'd0, vel_y},       m_v);
    chk({ph, ".scroll"},  {6'd0, scroll},       m_scroll);
    chk({ph, ".facing"},  {15'd0, facing_left}, m_face);
    chk({ph, ".falling"}, {15'd0, falling},     (m_state == M_FALL) ? 1 : 0);
    chk({ph, ".dead"},    {15'd0, dead},        (m_state == M_DEAD) ? 1 : 0);
    chk({ph, ".upd"},     {15'd0, upd},         m_upd);
  endtask

  // Drive inputs, take one clock edge, advance the model, check 1 ns later.
  task automatic cycle(input string ph, input bit st, input bit tk, input bit ml,
                       input bit mr, input bit ld);
    start = st; frame_tick = tk; move_left = ml; move_right = mr; land = ld;
    @(posedge clk);
    model_edge(st, tk, ml, mr, ld);
    #1;
    check_all(ph);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
    move_left = 1'b0; move_right = 1'b0; land = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.upd0", {15'd0, upd}, 0);
    rst = 1'b0;

    // frame_tick alone in IDLE does nothing; start plus tick spawns without motion.
    cycle("idle_tick", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start.vel", {12'd0, vel_y}, 12);

    // Twelve rising frames with a spare cycle between ticks.
    for (int i = 0; i < 12; i++) begin
      cycle("rise", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("rise78.pos_y", {6'd0, pos_y}, 322);
    chk("rise78.falling", {15'd0, falling}, 1);

    // Fall three frames to vel 3, then land (start ignored while airborne).
    for (int i = 0; i < 3; i++) cycle("fall3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fall3.vel", {12'd0, vel_y}, 3);
    cycle("land", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("land.vel", {12'd0, vel_y}, 12);
    chk("land.pos_y", {6'd0, pos_y}, 328);
    chk("land.upd", {15'd0, upd}, 1);

    // Climb to the ceiling: 328 -> 250 -> 172 -> clamped at 160 with scroll.
    for (int i = 0; i < 12; i++) cycle("climb1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("land2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle("climb2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("climb2.pos_y", {6'd0, pos_y}, 172);
    cycle("land3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("ceil0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ceil0.pos_y", {6'd0, pos_y}, 160);
    chk("ceil0.scroll", {6'd0, scroll}, 0);
    cycle("ceil1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ceil1.scroll", {6'd0, scroll}, 11);
    cycle("hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold.scroll", {6'd0, scroll}, 11);

    // Horizontal wrap while bouncing (land held keeps the player airborne).
    for (int i = 0; i < 76; i++) cycle("left", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("wrapl.pos_x", {6'd0, pos_x}, 636);
    chk("wrapl.facing", {15'd0, facing_left}, 1);
    cycle("right", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("wrapr.pos_x", {6'd0, pos_x}, 0);
    chk("wrapr.facing", {15'd0, facing_left}, 0);
    cycle("both", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle("left1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle("both2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("both2.facing", {15'd0, facing_left}, 1);

    // Fall to death, bounded by a frame budget.
    for (int i = 0; i < 80; i++) begin
      if (m_state != M_DEAD) cycle("todeath", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("death.dead", {15'd0, dead}, 1);
    chk("death.pos_y", {6'd0, pos_y}, 420);
    chk("death.upd", {15'd0, upd}, 1);
    for (int i = 0; i < 3; i++) cycle("frozen", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart.pos_x", {6'd0, pos_x}, 300);
    chk("restart.pos_y", {6'd0, pos_y}, 400);

    // Into FALLING, then assert reset between clock edges.
    for (int i = 0; i < 14; i++) cycle("prefall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    frame_tick = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized play against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
